// File: rtl/csr_unit_pkg.sv
// Shared types, CSR address map and the read-modify-write helper for the CSR execution unit.
package csr_unit_pkg;

    localparam int CSR_XLEN = 32;

    localparam logic [11:0] CSR_ADDR_SCRATCH_BASE = 12'h7C0;
    localparam logic [11:0] CSR_ADDR_MCYCLE       = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MCYCLEH      = 12'hB80;
    localparam logic [11:0] CSR_ADDR_MINSTRET     = 12'hB02;
    localparam logic [11:0] CSR_ADDR_MINSTRETH    = 12'hB82;
    localparam logic [11:0] CSR_ADDR_CYCLE        = 12'hC00;
    localparam logic [11:0] CSR_ADDR_CYCLEH       = 12'hC80;
    localparam logic [11:0] CSR_ADDR_INSTRET      = 12'hC02;
    localparam logic [11:0] CSR_ADDR_INSTRETH     = 12'hC82;

    typedef enum logic [1:0] {
        CSR_WF_NONE = 2'd0,
        CSR_WF_RW   = 2'd1,
        CSR_WF_RS   = 2'd2,
        CSR_WF_RC   = 2'd3
    } csr_write_func_e;

    typedef enum logic {
        CSR_SRC_REG = 1'b0,
        CSR_SRC_IMM = 1'b1
    } csr_src_e;

    typedef struct packed {
        logic            read_enable;
        logic            write_enable;
        csr_src_e        input_select;
        csr_write_func_e write_func;
    } csr_params_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } csr_unit_state_e;

    function automatic logic [CSR_XLEN-1:0] csr_apply_write(
        input logic [CSR_XLEN-1:0] old_val,
        input logic [CSR_XLEN-1:0] src_val,
        input csr_write_func_e     func
    );
        logic [CSR_XLEN-1:0] result;
        case (func)
            CSR_WF_RW: result = src_val;
            CSR_WF_RS: result = old_val | src_val;
            CSR_WF_RC: result = old_val & ~src_val;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_unit_counter64.sv
// 64-bit free-running counter with 32-bit half writes; a write to either half
// replaces that cycle's increment, the other half keeps its pre-increment value.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        wrap
);

    logic [63:0] count;
    logic [63:0] count_next;

    always_comb begin
        count_next = count;
        if (wr_lo) begin
            count_next = {count[63:32], wdata};
        end else if (wr_hi) begin
            count_next = {wdata, count[31:0]};
        end else if (inc) begin
            count_next = count + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign lo   = count[31:0];
    assign hi   = count[63:32];
    assign wrap = inc & ~wr_lo & ~wr_hi & (&count);

endmodule

// File: rtl/csr_unit.sv
// Sequential CSR unit: accepts one request, performs the atomic read-modify-write
// on the scratch bank or counters in a single EXEC cycle, then holds the response.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int NUM_SCRATCH     = 4,
    parameter int ENABLE_COUNTERS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  csr_params_t       req_csr,
    input  logic [11:0]       req_addr,
    input  logic [XLEN-1:0]   req_rs1_val,
    input  logic [4:0]        req_uimm,
    input  logic              instr_retired,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_illegal
);

    localparam logic [4:0] SCRATCH_COUNT = NUM_SCRATCH[4:0];

    csr_unit_state_e state;
    csr_unit_state_e state_next;

    csr_params_t     csr_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;

    logic [XLEN-1:0] scratch [NUM_SCRATCH];

    logic            accept;
    logic            exec;
    logic            active;
    logic            mapped;
    logic            is_scratch;
    logic            illegal;
    logic            do_write;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] rdata_next;

    logic [31:0]     cyc_lo;
    logic [31:0]     cyc_hi;
    logic [31:0]     ret_lo;
    logic [31:0]     ret_hi;
    logic            cyc_wr_lo;
    logic            cyc_wr_hi;
    logic            ret_wr_lo;
    logic            ret_wr_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid & req_ready;
    assign exec       = (state == EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_q  <= '0;
            addr_q <= '0;
            src_q  <= '0;
        end else if (accept) begin
            csr_q  <= req_csr;
            addr_q <= req_addr;
            src_q  <= (req_csr.input_select == CSR_SRC_IMM)
                      ? {{(XLEN-5){1'b0}}, req_uimm} : req_rs1_val;
        end
    end

    assign is_scratch = (addr_q[11:4] == CSR_ADDR_SCRATCH_BASE[11:4])
                        && ({1'b0, addr_q[3:0]} < SCRATCH_COUNT);

    // Counter values are registered, so reads here see the pre-increment value.
    always_comb begin
        old_val = '0;
        mapped  = 1'b0;
        if (is_scratch) begin
            mapped = 1'b1;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (addr_q[3:0] == i[3:0]) old_val = scratch[i];
            end
        end else if (ENABLE_COUNTERS != 0) begin
            case (addr_q)
                CSR_ADDR_MCYCLE, CSR_ADDR_CYCLE: begin
                    old_val = cyc_lo;
                    mapped  = 1'b1;
                end
                CSR_ADDR_MCYCLEH, CSR_ADDR_CYCLEH: begin
                    old_val = cyc_hi;
                    mapped  = 1'b1;
                end
                CSR_ADDR_MINSTRET, CSR_ADDR_INSTRET: begin
                    old_val = ret_lo;
                    mapped  = 1'b1;
                end
                CSR_ADDR_MINSTRETH, CSR_ADDR_INSTRETH: begin
                    old_val = ret_hi;
                    mapped  = 1'b1;
                end
                default: begin
                    old_val = '0;
                    mapped  = 1'b0;
                end
            endcase
        end
    end

    // A NONE operation is not a CSR access at all, so it can never be illegal.
    assign active     = (csr_q.write_func != CSR_WF_NONE);
    assign illegal    = active && (!mapped
                        || (csr_q.write_enable && (addr_q[11:10] == 2'b11)));
    assign do_write   = exec && active && !illegal && csr_q.write_enable;
    assign new_val    = csr_apply_write(old_val, src_q, csr_q.write_func);
    assign rdata_next = (active && !illegal && csr_q.read_enable) ? old_val : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else if (do_write && is_scratch) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (addr_q[3:0] == i[3:0]) scratch[i] <= new_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata   <= '0;
            resp_illegal <= 1'b0;
        end else if (exec) begin
            resp_rdata   <= rdata_next;
            resp_illegal <= illegal;
        end
    end

    assign cyc_wr_lo = do_write && (addr_q == CSR_ADDR_MCYCLE);
    assign cyc_wr_hi = do_write && (addr_q == CSR_ADDR_MCYCLEH);
    assign ret_wr_lo = do_write && (addr_q == CSR_ADDR_MINSTRET);
    assign ret_wr_hi = do_write && (addr_q == CSR_ADDR_MINSTRETH);

    if (ENABLE_COUNTERS != 0) begin : g_counters
        csr_counter64 u_cycle (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (1'b1),
            .wr_lo (cyc_wr_lo),
            .wr_hi (cyc_wr_hi),
            .wdata (new_val),
            .lo    (cyc_lo),
            .hi    (cyc_hi),
            .wrap  ()
        );

        csr_counter64 u_instret (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (instr_retired),
            .wr_lo (ret_wr_lo),
            .wr_hi (ret_wr_hi),
            .wdata (new_val),
            .lo    (ret_lo),
            .hi    (ret_hi),
            .wrap  ()
        );
    end else begin : g_no_counters
        assign cyc_lo = '0;
        assign cyc_hi = '0;
        assign ret_lo = '0;
        assign ret_hi = '0;
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: handshake latency, RW/RS/RC, counters, illegal
// accesses, response back-pressure and reset during an operation.
module tb_csr_unit;
    import csr_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    csr_params_t req_csr;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_val;
    logic [4:0]  req_uimm;
    logic        instr_retired;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd;
    logic        ill;
    int          lat;

    always #5 clk = ~clk;

    csr_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_csr       (req_csr),
        .req_addr      (req_addr),
        .req_rs1_val   (req_rs1_val),
        .req_uimm      (req_uimm),
        .instr_retired (instr_retired),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_illegal  (resp_illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input csr_write_func_e f, input logic re, input logic we,
                           input logic imm, input logic [11:0] a,
                           input logic [31:0] rs1, input logic [4:0] u);
        req_csr.read_enable  = re;
        req_csr.write_enable = we;
        req_csr.input_select = imm ? CSR_SRC_IMM : CSR_SRC_REG;
        req_csr.write_func   = f;
        req_addr             = a;
        req_rs1_val          = rs1;
        req_uimm             = u;
    endtask

    // One full transaction with resp_ready held high; returns just after the
    // response handshake edge.
    task automatic do_req(input csr_write_func_e f, input logic re, input logic we,
                          input logic imm, input logic [11:0] a,
                          input logic [31:0] rs1, input logic [4:0] u);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        set_req(f, re, we, imm, a, rs1, u);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check_eq("resp_valid_timeout", {31'b0, resp_valid}, 32'd1);
        rd  = resp_rdata;
        ill = resp_illegal;
        @(posedge clk);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        resp_ready    = 1'b1;
        instr_retired = 1'b0;
        set_req(CSR_WF_NONE, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0);

        repeat (2) @(negedge clk);
        check_eq("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check_eq("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("reset_resp_rdata", resp_rdata, 32'h0);
        check_eq("reset_resp_illegal", {31'b0, resp_illegal}, 32'd0);

        // Release on a falling edge; the cycle counter then counts rising edges.
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hC00, 32'h0, 5'h0);
        check_eq("cycle_first_read", rd, 32'd11);
        check_eq("cycle_first_illegal", {31'b0, ill}, 32'd0);
        check_eq("first_latency", lat, 32'd2);

        // Scratch read-modify-write chain.
        do_req(CSR_WF_RW, 1'b1, 1'b1, 1'b0, 12'h7C1, 32'hDEAD_BEEF, 5'h0);
        check_eq("scr_rw_old", rd, 32'h0);
        do_req(CSR_WF_RS, 1'b1, 1'b1, 1'b1, 12'h7C1, 32'hFFFF_FFFF, 5'h5);
        check_eq("scr_rs_old", rd, 32'hDEAD_BEEF);
        do_req(CSR_WF_RC, 1'b1, 1'b1, 1'b0, 12'h7C1, 32'hFFFF_0000, 5'h0);
        check_eq("scr_rc_old", rd, 32'hDEAD_BEEF);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'h7C1, 32'h0, 5'h0);
        check_eq("scr_final", rd, 32'h0000_BEEF);

        do_req(CSR_WF_NONE, 1'b1, 1'b1, 1'b0, 12'h7C1, 32'h1, 5'h0);
        check_eq("none_rdata", rd, 32'h0);
        check_eq("none_illegal", {31'b0, ill}, 32'd0);

        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'h7C4, 32'h0, 5'h0);
        check_eq("unmapped_illegal", {31'b0, ill}, 32'd1);
        check_eq("unmapped_rdata", rd, 32'h0);

        do_req(CSR_WF_RW, 1'b0, 1'b1, 1'b0, 12'h7C3, 32'h1234_5678, 5'h0);
        check_eq("noread_rdata", rd, 32'h0);
        check_eq("noread_illegal", {31'b0, ill}, 32'd0);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'h7C3, 32'h0, 5'h0);
        check_eq("noread_written", rd, 32'h1234_5678);

        // High half first so the low-half write leaves the counter at all-ones.
        do_req(CSR_WF_RW, 1'b1, 1'b1, 1'b0, 12'hB80, 32'hFFFF_FFFF, 5'h0);
        check_eq("mcycleh_old", rd, 32'h0);
        do_req(CSR_WF_RW, 1'b1, 1'b1, 1'b0, 12'hB00, 32'hFFFF_FFFF, 5'h0);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hB80, 32'h0, 5'h0);
        check_eq("mcycleh_wrapped", rd, 32'h0);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hB00, 32'h0, 5'h0);
        check_eq("mcycle_after_wrap", rd, 32'd4);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hC80, 32'h0, 5'h0);
        check_eq("cycleh_mirror", rd, 32'h0);

        // Three retired instructions.
        @(negedge clk);
        instr_retired = 1'b1;
        repeat (3) @(negedge clk);
        instr_retired = 1'b0;
        do_req(CSR_WF_RW, 1'b1, 1'b1, 1'b0, 12'hC02, 32'h0000_1234, 5'h0);
        check_eq("instret_wr_illegal", {31'b0, ill}, 32'd1);
        check_eq("instret_wr_rdata", rd, 32'h0);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hC02, 32'h0, 5'h0);
        check_eq("instret_rd_illegal", {31'b0, ill}, 32'd0);
        check_eq("instret_rd_value", rd, 32'd3);
        do_req(CSR_WF_RW, 1'b1, 1'b1, 1'b0, 12'hB02, 32'd100, 5'h0);
        check_eq("minstret_old", rd, 32'd3);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hC02, 32'h0, 5'h0);
        check_eq("instret_mirror", rd, 32'd100);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hB82, 32'h0, 5'h0);
        check_eq("minstreth", rd, 32'h0);

        // Response back-pressure with a second request waiting.
        @(negedge clk);
        resp_ready = 1'b0;
        set_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'h7C1, 32'h0, 5'h0);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        set_req(CSR_WF_RW, 1'b1, 1'b1, 1'b0, 12'h7C2, 32'h0000_0055, 5'h0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_rdata", resp_rdata, 32'h0000_BEEF);
            check_eq("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
            check_eq("bp_hold_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_after_req_ready", {31'b0, req_ready}, 32'd1);
        check_eq("bp_after_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_second_valid", {31'b0, resp_valid}, 32'd1);
        check_eq("bp_second_rdata", resp_rdata, 32'h0);
        @(posedge clk);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'h7C2, 32'h0, 5'h0);
        check_eq("bp_second_written", rd, 32'h0000_0055);

        // Reset asserted while a write is in EXEC.
        @(negedge clk);
        set_req(CSR_WF_RW, 1'b1, 1'b1, 1'b0, 12'h7C0, 32'hAAAA_5555, 5'h0);
        req_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_exec_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_exec_req_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst_exec_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'hC00, 32'h0, 5'h0);
        check_eq("rst_cycle_restart", rd, 32'd2);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'h7C0, 32'h0, 5'h0);
        check_eq("rst_scratch0", rd, 32'h0);
        do_req(CSR_WF_RS, 1'b1, 1'b0, 1'b0, 12'h7C1, 32'h0, 5'h0);
        check_eq("rst_scratch1", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
